// File: rtl/clearable_ram.sv
// clearable_ram
// Single-clock RAM with per-lane write enables, a registered read port and a
// whole-array clear sweep.
//
// Parameters
//   MEM_SIZE  number of words (>= 1)
//   DATA_W    word width in bits
//   LANES     write-enable lanes; DATA_W must be a multiple of LANES
//
// Ports
//   clock       in   single clock, all logic on posedge
//   reset       in   synchronous, active-high; restarts the clear sweep
//   write       in   write request
//   wr_lane_en  in   per-lane write enable, lane k = bits [(k+1)*LANE_W-1 : k*LANE_W]
//   datain      in   write data
//   addr_w      in   write address
//   read        in   read request
//   addr_r      in   read address
//   clear       in   request to zero the whole array
//   dataout     out  registered read data (holds between reads)
//   rvalid      out  one-cycle pulse with each new read result
//   busy        out  high while the clear sweep runs; requests ignored
//   addr_err    out  one-cycle pulse for an accepted out-of-range request
//
// Optional feature
//   CLEARABLE_RAM_BYPASS_EN  when defined, a read that collides with an
//   accepted write to the same address returns the lane-merged new word;
//   otherwise the old word is returned.
//
// FSM states
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_CLEAR | sweep zeroes mem[clr_ptr], clr_ptr 0..MEM_SIZE-1; busy=1
//   ST_IDLE  | normal read/write service; clear starts a new sweep

module clearable_ram #(
    parameter  int MEM_SIZE = 6,
    parameter  int DATA_W   = 10,
    parameter  int LANES    = 2,
    localparam int LANE_W   = DATA_W / LANES,
    localparam int ADDR_W   = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              write,
    input  logic [LANES-1:0]  wr_lane_en,
    input  logic [DATA_W-1:0] datain,
    input  logic [ADDR_W-1:0] addr_w,
    input  logic              read,
    input  logic [ADDR_W-1:0] addr_r,
    input  logic              clear,
    output logic [DATA_W-1:0] dataout,
    output logic              rvalid,
    output logic              busy,
    output logic              addr_err
);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    // One extra bit so MEM_SIZE itself is representable for range compares.
    localparam logic [ADDR_W:0]   MEM_SIZE_A = MEM_SIZE[ADDR_W:0];
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(MEM_SIZE - 1);

    logic [DATA_W-1:0] mem_q [MEM_SIZE];

    state_t            state_q,    state_d;
    logic [ADDR_W-1:0] clr_ptr_q,  clr_ptr_d;
    logic [DATA_W-1:0] dataout_q,  dataout_d;
    logic              rvalid_q,   rvalid_d;
    logic              addr_err_q, addr_err_d;

    logic              idle;
    logic              wr_req;
    logic              rd_req;
    logic              wr_in_range;
    logic              rd_in_range;
    logic              wr_acc;
    logic [DATA_W-1:0] lane_mask;
    logic [DATA_W-1:0] rd_old;
    logic [DATA_W-1:0] rd_data;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_wmask;

    // Expand per-lane enables into a per-bit mask.
    always_comb begin
        lane_mask = '0;
        for (int k = 0; k < LANES; k++) begin
            lane_mask[k*LANE_W +: LANE_W] = {LANE_W{wr_lane_en[k]}};
        end
    end

    always_comb begin
        idle        = (state_q == ST_IDLE);
        wr_req      = write && idle;
        rd_req      = read  && idle;
        wr_in_range = ({1'b0, addr_w} < MEM_SIZE_A);
        rd_in_range = ({1'b0, addr_r} < MEM_SIZE_A);
        wr_acc      = wr_req && wr_in_range;
    end

    // Read data path, including the optional same-address write bypass.
    always_comb begin
        rd_old = '0;
        if (rd_in_range) begin
            rd_old = mem_q[addr_r];
        end
        rd_data = rd_old;
`ifdef CLEARABLE_RAM_BYPASS_EN
        if (rd_in_range && wr_acc && (addr_w == addr_r)) begin
            rd_data = (rd_old & ~lane_mask) | (datain & lane_mask);
        end
`endif
    end

    // Array write port: the sweep owns it while busy, the user port otherwise.
    // Nothing is written in a reset cycle.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = '0;
        mem_wdata = '0;
        mem_wmask = '0;
        if (!reset) begin
            if (state_q == ST_CLEAR) begin
                mem_we    = 1'b1;
                mem_waddr = clr_ptr_q;
                mem_wdata = '0;
                mem_wmask = '1;
            end else if (wr_acc) begin
                mem_we    = 1'b1;
                mem_waddr = addr_w;
                mem_wdata = datain;
                mem_wmask = lane_mask;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        clr_ptr_d  = clr_ptr_q;
        dataout_d  = dataout_q;
        rvalid_d   = 1'b0;
        addr_err_d = 1'b0;

        case (state_q)
            ST_CLEAR: begin
                if (clr_ptr_q == LAST_ADDR) begin
                    state_d   = ST_IDLE;
                    clr_ptr_d = '0;
                end else begin
                    clr_ptr_d = clr_ptr_q + 1'b1;
                end
            end
            ST_IDLE: begin
                // Read and write in the clear cycle still complete; the sweep
                // begins at the following edge.
                if (clear) begin
                    state_d   = ST_CLEAR;
                    clr_ptr_d = '0;
                end
                if (rd_req) begin
                    rvalid_d  = 1'b1;
                    dataout_d = rd_data;
                end
                if ((rd_req && !rd_in_range) || (wr_req && !wr_in_range)) begin
                    addr_err_d = 1'b1;
                end
            end
            default: begin
                state_d   = ST_CLEAR;
                clr_ptr_d = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_CLEAR;
            clr_ptr_q  <= '0;
            dataout_q  <= '0;
            rvalid_q   <= 1'b0;
            addr_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_ptr_q  <= clr_ptr_d;
            dataout_q  <= dataout_d;
            rvalid_q   <= rvalid_d;
            addr_err_q <= addr_err_d;
        end
    end

    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= (mem_q[mem_waddr] & ~mem_wmask) | (mem_wdata & mem_wmask);
        end
    end

    assign dataout  = dataout_q;
    assign rvalid   = rvalid_q;
    assign busy     = (state_q == ST_CLEAR);
    assign addr_err = addr_err_q;

endmodule

// File: tb/tb_clearable_ram.sv
module tb_clearable_ram;

    localparam int MEM_SIZE = 6;
    localparam int DATA_W   = 10;
    localparam int LANES    = 2;
    localparam int ADDR_W   = 3;

    logic              clock;
    logic              reset;
    logic              write;
    logic [LANES-1:0]  wr_lane_en;
    logic [DATA_W-1:0] datain;
    logic [ADDR_W-1:0] addr_w;
    logic              read;
    logic [ADDR_W-1:0] addr_r;
    logic              clear;
    logic [DATA_W-1:0] dataout;
    logic              rvalid;
    logic              busy;
    logic              addr_err;

    int checks;
    int errors;
    int n;

    clearable_ram #(
        .MEM_SIZE (MEM_SIZE),
        .DATA_W   (DATA_W),
        .LANES    (LANES)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .write      (write),
        .wr_lane_en (wr_lane_en),
        .datain     (datain),
        .addr_w     (addr_w),
        .read       (read),
        .addr_r     (addr_r),
        .clear      (clear),
        .dataout    (dataout),
        .rvalid     (rvalid),
        .busy       (busy),
        .addr_err   (addr_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                            input logic [LANES-1:0] l);
        write = 1'b1; addr_w = a; datain = d; wr_lane_en = l;
        step();
        write = 1'b0;
    endtask

    task automatic do_read(input logic [ADDR_W-1:0] a);
        read = 1'b1; addr_r = a;
        step();
        read = 1'b0;
    endtask

    task automatic count_busy();
        n = 0;
        while (busy && n < 20) begin
            step();
            n++;
        end
    endtask

    initial begin
        checks = 0; errors = 0;
        reset = 1'b1; write = 1'b0; read = 1'b0; clear = 1'b0;
        wr_lane_en = '0; datain = '0; addr_w = '0; addr_r = '0;

        step(); step();
        check("rst_dataout", dataout, 0);
        check("rst_rvalid", rvalid, 0);
        check("rst_addr_err", addr_err, 0);
        check("rst_busy", busy, 1);

        // Initial sweep: busy for exactly MEM_SIZE cycles, array zeroed.
        reset = 1'b0;
        count_busy();
        check("init_busy_cycles", n, 6);
        for (int i = 0; i < MEM_SIZE; i++) begin
            do_read(ADDR_W'(i));
            check("init_read_data", dataout, 0);
            check("init_read_rvalid", rvalid, 1);
        end
        step();
        check("idle_rvalid_low", rvalid, 0);

        // Lane-masked writes.
        do_write(3'd3, 10'h3FF, 2'b11);
        do_write(3'd3, 10'h000, 2'b01);
        do_read(3'd3);
        check("lane_merge", dataout, 10'h3E0);
        step();
        check("dataout_hold", dataout, 10'h3E0);

        // Same-address collisions.
        do_write(3'd2, 10'h155, 2'b11);
        write = 1'b1; addr_w = 3'd2; datain = 10'h2AA; wr_lane_en = 2'b11;
        read = 1'b1; addr_r = 3'd2;
        step();
        write = 1'b0; read = 1'b0;
`ifdef CLEARABLE_RAM_BYPASS_EN
        check("collide_full", dataout, 10'h2AA);
`else
        check("collide_full", dataout, 10'h155);
`endif
        do_read(3'd2);
        check("collide_write_done", dataout, 10'h2AA);

        write = 1'b1; addr_w = 3'd2; datain = 10'h155; wr_lane_en = 2'b10;
        read = 1'b1; addr_r = 3'd2;
        step();
        write = 1'b0; read = 1'b0;
`ifdef CLEARABLE_RAM_BYPASS_EN
        check("collide_lane", dataout, 10'h14A);
`else
        check("collide_lane", dataout, 10'h2AA);
`endif
        check("collide_no_err", addr_err, 0);

        // Out-of-range accesses.
        do_read(3'd7);
        check("oob_rd_data", dataout, 0);
        check("oob_rd_rvalid", rvalid, 1);
        check("oob_rd_err", addr_err, 1);
        step();
        check("oob_err_drop", addr_err, 0);
        do_write(3'd6, 10'h3FF, 2'b11);
        check("oob_wr_err", addr_err, 1);
        check("oob_wr_rvalid", rvalid, 0);
        step();
        check("oob_wr_err_drop", addr_err, 0);
        do_read(3'd0); check("oob_keep_0", dataout, 10'h000);
        do_read(3'd1); check("oob_keep_1", dataout, 10'h000);
        do_read(3'd2); check("oob_keep_2", dataout, 10'h14A);
        do_read(3'd3); check("oob_keep_3", dataout, 10'h3E0);
        do_read(3'd4); check("oob_keep_4", dataout, 10'h000);
        do_read(3'd5); check("oob_keep_5", dataout, 10'h000);

        // Independent write and read on different addresses.
        write = 1'b1; addr_w = 3'd4; datain = 10'h0AB; wr_lane_en = 2'b11;
        read = 1'b1; addr_r = 3'd3;
        step();
        write = 1'b0; read = 1'b0;
        check("indep_read", dataout, 10'h3E0);
        do_read(3'd4);
        check("indep_write", dataout, 10'h0AB);

        // Clear with requests held during busy; repeated clear must not restart.
        for (int i = 0; i < MEM_SIZE; i++) do_write(ADDR_W'(i), 10'h1FF, 2'b11);
        do_read(3'd5);
        check("fill_read", dataout, 10'h1FF);
        clear = 1'b1;
        step();
        check("clear_busy", busy, 1);
        read = 1'b1; addr_r = 3'd1;
        write = 1'b1; addr_w = 3'd1; datain = 10'h3FF; wr_lane_en = 2'b11;
        n = 0;
        while (busy && n < 20) begin
            step();
            n++;
            check("busy_rvalid_low", rvalid, 0);
        end
        read = 1'b0; write = 1'b0; clear = 1'b0;
        check("clear_busy_cycles", n, 6);
        check("clear_hold_data", dataout, 10'h1FF);
        for (int i = 0; i < MEM_SIZE; i++) begin
            do_read(ADDR_W'(i));
            check("clear_zero", dataout, 0);
        end

        // Reset in the middle of a sweep restarts it and drops the read result.
        do_write(3'd5, 10'h2AA, 2'b11);
        do_read(3'd5);
        check("pre_reset_data", dataout, 10'h2AA);
        clear = 1'b1;
        step();
        clear = 1'b0;
        step(); step(); step();
        check("mid_sweep_busy", busy, 1);
        reset = 1'b1; read = 1'b1; addr_r = 3'd5;
        step();
        read = 1'b0;
        check("mid_rst_dataout", dataout, 0);
        check("mid_rst_rvalid", rvalid, 0);
        check("mid_rst_busy", busy, 1);
        reset = 1'b0;
        count_busy();
        check("restart_busy_cycles", n, 6);
        do_read(3'd5);
        check("restart_zero", dataout, 0);
        check("restart_rvalid", rvalid, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/clearable_ram.md
CLEARABLE_RAM -- requirements
Module: clearable_ram

Interface
REQ-001 Parameter MEM_SIZE, default 6, number of words (>=1).
REQ-002 Parameter DATA_W, default 10, word width in bits.
REQ-003 Parameter LANES, default 2, write-enable lanes; DATA_W SHALL be divisible by LANES; LANE_W = DATA_W/LANES.
REQ-004 Derived ADDR_W SHALL equal max(1, $clog2(MEM_SIZE)).
REQ-005 clock  input  1  single clock; all logic on posedge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 write  input  1  write request.
REQ-008 wr_lane_en  input  LANES  per-lane write enable; lane k covers bits [(k+1)*LANE_W-1 : k*LANE_W].
REQ-009 datain  input  DATA_W  write data.
REQ-010 addr_w  input  ADDR_W  write address.
REQ-011 read  input  1  read request.
REQ-012 addr_r  input  ADDR_W  read address.
REQ-013 clear  input  1  request to zero the whole array.
REQ-014 dataout  output  DATA_W  registered read data.
REQ-015 rvalid  output  1  one-cycle pulse when dataout carries a new read result.
REQ-016 busy  output  1  high while the clear sweep runs; requests are ignored while high.
REQ-017 addr_err  output  1  one-cycle pulse on an accepted request with address >= MEM_SIZE.

Function
REQ-018 FSM states: CLEAR, IDLE; busy SHALL equal (state == CLEAR).
REQ-019 CLEAR: writes zero to address clr_ptr each cycle, clr_ptr 0..MEM_SIZE-1; after the write to MEM_SIZE-1 it transitions to IDLE.
REQ-020 IDLE -> CLEAR when clear=1 at an edge; clr_ptr <= 0; clear while busy SHALL be ignored, and the sweep SHALL NOT restart.
REQ-021 Write accepted when write=1, busy=0, addr_w < MEM_SIZE; only lanes with wr_lane_en[k]=1 update; wr_lane_en=0 leaves the word unchanged.
REQ-022 Read accepted when read=1, busy=0; latency 1: at the next edge dataout <= mem[addr_r] and rvalid <= 1.
REQ-023 No accepted read: rvalid <= 0 and dataout holds its last value.
REQ-024 Read with addr_r >= MEM_SIZE: dataout <= 0, rvalid <= 1, addr_err <= 1.
REQ-025 Write with addr_w >= MEM_SIZE: no array change, addr_err <= 1.
REQ-026 addr_err SHALL be 0 in every cycle after one with no out-of-range accepted request.
REQ-027 clear, write and read in the same IDLE cycle: the write and the read are performed (read returns pre-clear data), and the sweep starts at the next edge.
REQ-028 Simultaneous write and read to different addresses SHALL be independent.

Reset
REQ-029 While reset=1 at an edge: state <= CLEAR, clr_ptr <= 0, dataout <= 0, rvalid <= 0, addr_err <= 0; the array is not written.
REQ-030 After reset deasserts, busy SHALL stay high for exactly MEM_SIZE cycles, during which the array is zeroed.
REQ-031 Reset asserted mid-sweep or mid-operation SHALL restart the sweep from address 0 and drop any pending read result.

Configuration
REQ-032 Macro CLEARABLE_RAM_BYPASS_EN defined: a read and an accepted write to the same address in the same cycle SHALL return the new data, lane-merged: enabled lanes from datain, other lanes from the old word.
REQ-033 Macro CLEARABLE_RAM_BYPASS_EN undefined: the same collision SHALL return the old word; the write still completes.

Verification (MEM_SIZE=6, DATA_W=10, LANES=2)
REQ-034 Release reset, then read addr 0..5 after busy falls -> busy high for exactly 6 cycles; every read gives dataout=0 and rvalid=1.
REQ-035 Write 0x3FF with lanes 2'b11 to addr 3, then write 0x000 with lanes 2'b01 to addr 3, then read addr 3 -> dataout=0x3E0.
REQ-036 Collision: word at addr 2 is 0x155; write 0x2AA with lanes 2'b11 and read addr 2 in the same cycle -> dataout=0x2AA with BYPASS_EN, 0x155 without.
REQ-037 Read addr 7 -> dataout=0, rvalid=1, addr_err=1 for one cycle; write addr 6 -> addr_err=1 and addr 0..5 unchanged.
REQ-038 Fill all words with 0x1FF, pulse clear, then assert read and write during busy -> rvalid stays 0 and no write occurs; after 6 cycles all words read 0.
REQ-039 Assert reset at sweep cycle 3 -> after release, busy high for a further full 6 cycles, and dataout=0 with rvalid=0 during reset.
